// File: rtl/free_list_pkg.sv
// -----------------------------------------------------------------------------
// free_list_pkg
// Shared rename-stage constants and the physical register tag type. The tag
// type is meant for reuse by the RAT, ROB and reservation stations.
// -----------------------------------------------------------------------------
package free_list_pkg;

  localparam int PREG_BITS       = 6;                        // physical tag width
  localparam int ARCH_REG_COUNT  = 32;                       // architectural registers
  localparam int NUM_PHYS_REGS   = 2 ** PREG_BITS;           // 64 physical registers
  localparam int FREE_LIST_DEPTH = NUM_PHYS_REGS - ARCH_REG_COUNT;

  typedef logic [PREG_BITS-1:0] phys_reg_t;

endpackage : free_list_pkg

// File: rtl/free_list_if.sv
// -----------------------------------------------------------------------------
// free_list_if
// Bundle between the free list and its clients.
// The rename/dispatch stage and the ROB commit port sit on the master side.
// The free list itself sits on the slave side.
//   dequeue            : allocate the head tag this cycle
//   phys_reg           : tag at head (valid only when not empty)
//   is_free_list_empty : no tag available
//   commit_valid       : a retiring instruction returns a tag
//   commit_old_pd      : previous mapping of the retiring rd
//   flush              : discard every non-retired allocation
//   free_count         : number of tags in the list
//   overflow_err       : sticky, a push was attempted while full
// -----------------------------------------------------------------------------
interface free_list_if
  import free_list_pkg::*;
#(
  parameter int PHYS_REG_BITS = PREG_BITS,
  parameter int DEPTH         = FREE_LIST_DEPTH
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     dequeue;
  logic [PHYS_REG_BITS-1:0] phys_reg;
  logic                     is_free_list_empty;
  logic                     commit_valid;
  logic [PHYS_REG_BITS-1:0] commit_old_pd;
  logic                     flush;
  logic [CNT_W-1:0]         free_count;
  logic                     overflow_err;

  modport master (
    output dequeue, commit_valid, commit_old_pd, flush,
    input  phys_reg, is_free_list_empty, free_count, overflow_err
  );

  modport slave (
    input  dequeue, commit_valid, commit_old_pd, flush,
    output phys_reg, is_free_list_empty, free_count, overflow_err
  );

endinterface : free_list_if

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
// Circular FIFO of unallocated physical register tags.
// - Rename pops the head tag.
// - ROB commit pushes the retiring rd's old mapping at the tail.
// - A retirement-head pointer remembers where head must return on a flush.
//   This gives single-cycle recovery of every speculative allocation.
// Ports:
//   clk : clock
//   rst : asynchronous, active-high reset
//   bus : free_list_if.slave (see free_list_if for the signal list)
// -----------------------------------------------------------------------------
module free_list
  import free_list_pkg::*;
#(
  parameter int PHYS_REG_BITS = PREG_BITS,
  parameter int ARCH_REGS     = ARCH_REG_COUNT,
  parameter int DEPTH         = FREE_LIST_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  free_list_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;   // MSB is the wrap bit

  typedef logic [PTR_W-1:0]         ptr_t;
  typedef logic [PHYS_REG_BITS-1:0] tag_t;

  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

  if ((DEPTH != (2 ** PHYS_REG_BITS) - ARCH_REGS) || ((DEPTH & (DEPTH - 1)) != 0))
  begin : g_bad_params
    $error("free_list: DEPTH must equal 2**PHYS_REG_BITS - ARCH_REGS and be a power of two");
  end

  tag_t r_mem [DEPTH];
  ptr_t r_head;
  ptr_t r_tail;
  ptr_t r_retire_head;
  logic r_overflow_err;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_overflow;
  ptr_t w_retire_head_next;

  // NOTE: every signal is assigned on every path through this block. A signal
  // left unassigned on some path would be inferred as a latch.
  always_comb begin
    w_empty            = (r_head == r_tail);
    w_full             = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) &&
                         (r_head[PTR_W-1]   != r_tail[PTR_W-1]);
    w_push             = bus.commit_valid && !w_full;
    w_overflow         = bus.commit_valid &&  w_full;
    // Flush wins over dequeue. Dequeue while empty is dropped, so commit_old_pd
    // is never bypassed to phys_reg in the same cycle.
    w_pop              = bus.dequeue && !w_empty && !bus.flush;
    w_retire_head_next = w_push ? (r_retire_head + PTR_ONE) : r_retire_head;
  end

  // All outputs come from registered state only. None of them depends
  // combinationally on this cycle's dequeue or commit inputs.
  assign bus.phys_reg           = r_mem[r_head[IDX_W-1:0]];
  assign bus.is_free_list_empty = w_empty;
  assign bus.free_count         = r_tail - r_head;
  assign bus.overflow_err       = r_overflow_err;

  // NOTE: the tag array is deliberately reset. At power-up the free list must
  // hold tags ARCH_REGS..2**PHYS_REG_BITS-1, so the array cannot be left at
  // random values the way plain data storage can.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= tag_t'(ARCH_REGS + i);
      end
      r_head         <= '0;
      r_retire_head  <= '0;
      r_tail         <= PTR_DEPTH;
      r_overflow_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here. Every read in this block sees the
      // pre-edge value, whatever the order of the statements.
      if (w_push) begin
        r_mem[r_tail[IDX_W-1:0]] <= bus.commit_old_pd;
        r_tail                   <= r_tail + PTR_ONE;
        r_retire_head            <= w_retire_head_next;
      end
      if (bus.flush) begin
        r_head <= w_retire_head_next;
      end else if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      if (w_overflow) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

  // Protocol misuse is reported, not fatal. The hardware already defines the
  // outcome of each case: the request is dropped, and overflow_err is set for
  // a commit while full.
  a_no_deq_empty : assert property (@(posedge clk) disable iff (rst)
    !(bus.dequeue && w_empty))
    else $warning("free_list: dequeue while empty");

  a_no_commit_full : assert property (@(posedge clk) disable iff (rst)
    !(bus.commit_valid && w_full))
    else $warning("free_list: commit while full");

  // Wrap-aware ordering. retire_head trails head, and head trails tail.
  // Flush moves head back to retire_head.
  a_ptr_order : assert property (@(posedge clk) disable iff (rst)
    ptr_t'(r_head - r_retire_head) <= ptr_t'(r_tail - r_retire_head))
    else $error("free_list: pointer order retire_head <= head <= tail broken");

endmodule : free_list
